// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: rotate, shift, serial-in, Johnson.
// Free-running steps or counted bursts with a busy/done handshake.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = {1'b1, {(WIDTH-1){1'b0}}},
  parameter int STEP_W = 16,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              pl,
  input  logic [WIDTH-1:0]  d,
  input  logic [2:0]        mode,
  input  logic [AMT_W-1:0]  amt,
  input  logic              si,
  input  logic              en,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  output logic [WIDTH-1:0]  y,
  output logic              so,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] cnt, cnt_nxt;
  logic [2:0]        mode_q, mode_nxt;
  logic [AMT_W-1:0]  amt_q, amt_nxt;
  logic [WIDTH-1:0]  y_nxt;
  logic              so_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic [2:0]         s_mode;
  logic [AMT_W-1:0]   s_amt;
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;
  logic [WIDTH-1:0]   step_y;
  logic               step_so;

  // One step of the selected operation; a burst uses its latched mode/amt.
  always_comb begin
    s_mode  = (state == RUN) ? mode_q : mode;
    s_amt   = (state == RUN) ? amt_q : amt;
    rol_w   = {y, y} << s_amt;
    ror_w   = {y, y} >> s_amt;
    step_y  = y;
    step_so = so;
    case (s_mode)
      3'd1: begin
        step_y  = rol_w[2*WIDTH-1:WIDTH];
        step_so = y[WIDTH-1];
      end
      3'd2: begin
        step_y  = ror_w[WIDTH-1:0];
        step_so = y[0];
      end
      3'd3: begin
        step_y  = {y[WIDTH-2:0], si};
        step_so = y[WIDTH-1];
      end
      3'd4: begin
        step_y  = {si, y[WIDTH-1:1]};
        step_so = y[0];
      end
      3'd5: begin
        step_y = $signed(y) >>> s_amt;
        if (s_amt != '0)
          step_so = y[s_amt - AMT_W'(1)];
      end
      3'd6: begin
        step_y  = {y[WIDTH-2:0], ~y[WIDTH-1]};
        step_so = y[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Next state: loads win and abort a burst, then burst step, then free run.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    amt_nxt   = amt_q;
    y_nxt     = y;
    so_nxt    = so;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    if (ld || pl) begin
      y_nxt     = ld ? INIT_VAL : d;
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else if (state == RUN) begin
      y_nxt   = step_y;
      so_nxt  = step_so;
      cnt_nxt = cnt - STEP_W'(1);
      if (cnt == STEP_W'(1)) begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
    end else if (start) begin
      if (steps != '0) begin
        mode_nxt  = mode;
        amt_nxt   = amt;
        cnt_nxt   = steps;
        state_nxt = RUN;
        busy_nxt  = 1'b1;
      end else begin
        done_nxt = 1'b1;
      end
    end else if (en) begin
      y_nxt  = step_y;
      so_nxt = step_so;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= '0;
      amt_q  <= '0;
      y      <= '0;
      so     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      amt_q  <= amt_nxt;
      y      <= y_nxt;
      so     <= so_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (WIDTH=8).
// Expected snapshots are queued with stimulus and popped after each edge.
module tb_universal_shift_register;

  typedef struct packed {
    logic [7:0] y;
    logic       so;
    logic       busy;
    logic       done;
  } snap_t;

  logic        clk;
  logic        rst;
  logic        ld;
  logic        pl;
  logic [7:0]  d;
  logic [2:0]  mode;
  logic [2:0]  amt;
  logic        si;
  logic        en;
  logic        start;
  logic [15:0] steps;
  logic [7:0]  y;
  logic        so;
  logic        busy;
  logic        done;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];

  universal_shift_register #(.WIDTH(8), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .ld(ld), .pl(pl), .d(d),
    .mode(mode), .amt(amt), .si(si), .en(en),
    .start(start), .steps(steps),
    .y(y), .so(so), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic snap_t snap();
    return {y, so, busy, done};
  endfunction

  function automatic snap_t mk(int vy, int vs, int vb, int vd);
    return {8'(vy), 1'(vs), 1'(vb), 1'(vd)};
  endfunction

  task automatic test_reset();
    snap_t e, g;
    string nm [3] = '{"busy_pre", "async_rst", "ld"};
    rst = 1'b1;
    pl = 1'b1;
    d = 8'h5A;
    tick();
    pl = 1'b0;
    start = 1'b1;
    mode = 3'd1;
    amt = 3'd1;
    steps = 16'd5;
    exp_q.push_back(mk('h5A, 0, 1, 0));
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        #3 rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1;
      end
      if (i == 2) begin
        #1 rst = 1'b1;
        tick();
        ld = 1'b1;
        exp_q.push_back(mk('h80, 0, 0, 0));
        tick();
        ld = 1'b0;
      end
      e = exp_q.pop_front();
      g = snap();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset %s got y=%h so=%b busy=%b done=%b exp y=%h so=%b busy=%b done=%b",
                 nm[i], g.y, g.so, g.busy, g.done, e.y, e.so, e.busy, e.done);
      end
    end
  endtask

  task automatic test_free_rotate();
    snap_t e, g;
    int ey [3] = '{'h01, 'h02, 'h04};
    int es [3] = '{1, 0, 0};
    mode = 3'd1;
    amt = 3'd1;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(ey[i], es[i], 0, 0));
      tick();
      e = exp_q.pop_front();
      g = snap();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL free_rot[%0d] got y=%h so=%b busy=%b done=%b exp y=%h so=%b busy=%b done=%b",
                 i, g.y, g.so, g.busy, g.done, e.y, e.so, e.busy, e.done);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_burst_rotate();
    snap_t e, g;
    int ey [11] = '{'h80, 'h80, 'h10, 'h02, 'h40, 'h08,
                    'h01, 'h20, 'h04, 'h80, 'h80};
    int es [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int eb [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int ed [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    ld = 1'b1;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(mk(ey[i], es[i], eb[i], ed[i]));
      tick();
      e = exp_q.pop_front();
      g = snap();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL burst[%0d] got y=%h so=%b busy=%b done=%b exp y=%h so=%b busy=%b done=%b",
                 i, g.y, g.so, g.busy, g.done, e.y, e.so, e.busy, e.done);
      end
      if (i == 0) begin
        ld = 1'b0;
        start = 1'b1;
        mode = 3'd2;
        amt = 3'd3;
        steps = 16'd8;
      end
      if (i == 1) begin
        start = 1'b0;
        mode = 3'd1;
        amt = 3'd1;
      end
      if (i == 3) begin
        start = 1'b1;
        steps = 16'd3;
      end
      if (i == 4) start = 1'b0;
    end
  endtask

  task automatic test_serial_arith();
    snap_t e, g;
    int lv [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int pv [12] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int dv [12] = '{'h0F, 0, 0, 'h90, 0, 0, 0, 0, 0, 0, 0, 'h33};
    int mv [12] = '{0, 3, 3, 0, 5, 5, 5, 4, 1, 7, 0, 0};
    int av [12] = '{0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0};
    int sv [12] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int ey [12] = '{'h0F, 'h1F, 'h3F, 'h90, 'hE4, 'hFC,
                    'hFC, 'hFE, 'hFE, 'hFE, 'hFE, 'h80};
    int es [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ld = 1'(lv[i]);
      pl = 1'(pv[i]);
      d = 8'(dv[i]);
      mode = 3'(mv[i]);
      amt = 3'(av[i]);
      si = 1'(sv[i]);
      exp_q.push_back(mk(ey[i], es[i], 0, 0));
      tick();
      e = exp_q.pop_front();
      g = snap();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL serial[%0d] got y=%h so=%b busy=%b done=%b exp y=%h so=%b busy=%b done=%b",
                 i, g.y, g.so, g.busy, g.done, e.y, e.so, e.busy, e.done);
      end
    end
    en = 1'b0;
    ld = 1'b0;
    pl = 1'b0;
    si = 1'b0;
  endtask

  task automatic test_johnson();
    snap_t e, g;
    int ey [17] = '{'h00, 'h01, 'h03, 'h07, 'h0F, 'h1F, 'h3F, 'h7F, 'hFF,
                    'hFE, 'hFC, 'hF8, 'hF0, 'hE0, 'hC0, 'h80, 'h00};
    int es [17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    pl = 1'b1;
    d = 8'h00;
    mode = 3'd6;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(mk(ey[i], es[i], 0, 0));
      tick();
      e = exp_q.pop_front();
      g = snap();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL johnson[%0d] got y=%h so=%b busy=%b done=%b exp y=%h so=%b busy=%b done=%b",
                 i, g.y, g.so, g.busy, g.done, e.y, e.so, e.busy, e.done);
      end
      pl = 1'b0;
      en = 1'b1;
    end
    en = 1'b0;
  endtask

  task automatic test_edge_cases();
    snap_t e, g;
    int lv [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int pv [18] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int tv [18] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
    int nv [18] = '{0, 0, 10, 0, 0, 0, 0, 0, 2, 7, 1, 1, 0, 0, 4, 0, 0, 0};
    int mv [18] = '{0, 0, 3, 3, 3, 3, 0, 0, 4, 4, 2, 2, 2, 2, 1, 1, 0, 0};
    int av [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    int sv [18] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int ey [18] = '{'h00, 'h00, 'h00, 'h01, 'h03, 'h07, 'hA5, 'hA5, 'hA5,
                    'h52, 'h29, 'h29, 'h94, 'h94, 'h94, 'h29, 'h80, 'h80};
    int es [18] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int eb [18] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0};
    int ed [18] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    d = 8'hA5;
    for (int i = 0; i < 18; i++) begin
      ld = 1'(lv[i]);
      pl = 1'(pv[i]);
      start = 1'(tv[i]);
      steps = 16'(nv[i]);
      mode = 3'(mv[i]);
      amt = 3'(av[i]);
      si = 1'(sv[i]);
      exp_q.push_back(mk(ey[i], es[i], eb[i], ed[i]));
      tick();
      e = exp_q.pop_front();
      g = snap();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL edge[%0d] got y=%h so=%b busy=%b done=%b exp y=%h so=%b busy=%b done=%b",
                 i, g.y, g.so, g.busy, g.done, e.y, e.so, e.busy, e.done);
      end
    end
    ld = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ld = 1'b0;
    pl = 1'b0;
    d = '0;
    mode = '0;
    amt = '0;
    si = 1'b0;
    en = 1'b0;
    start = 1'b0;
    steps = '0;
    #12;
    test_reset();
    test_free_rotate();
    test_burst_rotate();
    test_serial_arith();
    test_johnson();
    test_edge_cases();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
